// File: rtl/sdram_arbiter_if.sv
// Two-master request bundle plus the shared sys_sdram port and status lines.
// The arbiter sits on the slave side; masters and memory model use master.
interface sdram_arbiter_if;
    logic        m0_valid;
    logic        m0_ready;
    logic [31:0] m0_addr;
    logic [31:0] m0_wdata;
    logic [3:0]  m0_wstrb;
    logic [31:0] m0_rdata;
    logic        m1_valid;
    logic        m1_ready;
    logic [31:0] m1_addr;
    logic [31:0] m1_wdata;
    logic [3:0]  m1_wstrb;
    logic [31:0] m1_rdata;
    logic        s_valid;
    logic        s_ready;
    logic [31:0] s_addr;
    logic [31:0] s_wdata;
    logic [3:0]  s_wstrb;
    logic [31:0] s_rdata;
    logic [1:0]  grant;
    logic        init_done;
    logic        timeout_err;

    modport slave (
        input  m0_valid, m0_addr, m0_wdata, m0_wstrb,
        output m0_ready, m0_rdata,
        input  m1_valid, m1_addr, m1_wdata, m1_wstrb,
        output m1_ready, m1_rdata,
        output s_valid, s_addr, s_wdata, s_wstrb,
        input  s_ready, s_rdata,
        output grant, init_done, timeout_err
    );

    modport master (
        output m0_valid, m0_addr, m0_wdata, m0_wstrb,
        input  m0_ready, m0_rdata,
        output m1_valid, m1_addr, m1_wdata, m1_wstrb,
        input  m1_ready, m1_rdata,
        input  s_valid, s_addr, s_wdata, s_wstrb,
        output s_ready, s_rdata,
        input  grant, init_done, timeout_err
    );
endinterface

// File: rtl/sdram_arbiter.sv
// Two-master arbiter in front of the single sys_sdram valid/ready port.
// Sequences init wait, request/ready, ready-release and the optional watchdog.
module sdram_arbiter #(
    parameter bit          P_FIXED   = 1'b0,
    parameter logic [15:0] P_TIMEOUT = 16'd0
) (
    input logic            clk,
    input logic            rst_n,
    sdram_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        S_INIT,
        S_IDLE,
        S_REQ,
        S_WAIT
    } state_t;

    state_t      state;
    logic [1:0]  grant_q;
    logic        last;
    logic [15:0] cnt;
    logic        s_valid_q;
    logic        m0_ready_q;
    logic        m1_ready_q;
    logic [31:0] m0_rdata_q;
    logic [31:0] m1_rdata_q;
    logic        init_q;
    logic        terr_q;

    logic        both;
    logic        pick;
    logic        tmo_hit;
    logic        done;
    logic        active;
    logic [31:0] rd;

    always_comb begin
        both    = bus.m0_valid & bus.m1_valid;
        pick    = both ? (P_FIXED ? 1'b0 : ~last) : bus.m1_valid;
        tmo_hit = (P_TIMEOUT != 16'd0) && (cnt + 16'd1 == P_TIMEOUT);
        done    = bus.s_ready | tmo_hit;
        // a watchdog completion returns zero data
        rd      = bus.s_ready ? bus.s_rdata : 32'd0;
        active  = (state == S_REQ) || (state == S_WAIT);
    end

    assign bus.s_valid     = s_valid_q;
    assign bus.s_addr      = !active    ? 32'd0 :
                             grant_q[1] ? bus.m1_addr : bus.m0_addr;
    assign bus.s_wdata     = !active    ? 32'd0 :
                             grant_q[1] ? bus.m1_wdata : bus.m0_wdata;
    assign bus.s_wstrb     = !active    ? 4'd0 :
                             grant_q[1] ? bus.m1_wstrb : bus.m0_wstrb;
    assign bus.m0_ready    = m0_ready_q;
    assign bus.m1_ready    = m1_ready_q;
    assign bus.m0_rdata    = m0_rdata_q;
    assign bus.m1_rdata    = m1_rdata_q;
    assign bus.grant       = grant_q;
    assign bus.init_done   = init_q;
    assign bus.timeout_err = terr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_INIT;
            grant_q    <= 2'b00;
            last       <= 1'b1;
            cnt        <= 16'd0;
            s_valid_q  <= 1'b0;
            m0_ready_q <= 1'b0;
            m1_ready_q <= 1'b0;
            m0_rdata_q <= 32'd0;
            m1_rdata_q <= 32'd0;
            init_q     <= 1'b0;
            terr_q     <= 1'b0;
        end else begin
            m0_ready_q <= 1'b0;
            m1_ready_q <= 1'b0;
            unique case (state)
                S_INIT: begin
                    if (bus.s_ready) begin
                        init_q <= 1'b1;
                        state  <= S_IDLE;
                    end
                end
                S_IDLE: begin
                    if (bus.m0_valid | bus.m1_valid) begin
                        grant_q   <= pick ? 2'b10 : 2'b01;
                        s_valid_q <= 1'b1;
                        cnt       <= 16'd0;
                        state     <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (done) begin
                        s_valid_q <= 1'b0;
                        last      <= grant_q[1];
                        state     <= S_WAIT;
                        if (grant_q[1]) begin
                            m1_ready_q <= 1'b1;
                            m1_rdata_q <= rd;
                        end else begin
                            m0_ready_q <= 1'b1;
                            m0_rdata_q <= rd;
                        end
                        if (!bus.s_ready) begin
                            terr_q <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                S_WAIT: begin
                    if (!bus.s_ready) begin
                        grant_q <= 2'b00;
                        state   <= S_IDLE;
                    end
                end
                default: state <= S_INIT;
            endcase
        end
    end
endmodule

// File: tb/tb_sdram_arbiter.sv
// Bench: round-robin+watchdog(8) instance and fixed-priority instance,
// random masters and memory, compared each cycle against a behavioural model.
module tb_sdram_arbiter;
    logic clk;
    logic rst_n;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    logic [1:0]  mvalid [2];
    logic [31:0] maddr  [2][2];
    logic [31:0] mwdata [2][2];
    logic [3:0]  mwstrb [2][2];
    logic        sready [2];
    logic [31:0] srdata [2];
    logic [1:0]  mready [2];
    logic [31:0] mrdata [2][2];
    logic        svalid [2];
    logic [31:0] saddr  [2];
    logic [31:0] swdata [2];
    logic [3:0]  swstrb [2];
    logic [1:0]  grant  [2];
    logic        initd  [2];
    logic        terr   [2];

    sdram_arbiter_if ifa ();
    sdram_arbiter_if ifb ();

    sdram_arbiter #(.P_FIXED(1'b0), .P_TIMEOUT(16'd8)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(ifa)
    );
    sdram_arbiter #(.P_FIXED(1'b1), .P_TIMEOUT(16'd0)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(ifb)
    );

    assign ifa.m0_valid = mvalid[0][0];
    assign ifa.m0_addr  = maddr[0][0];
    assign ifa.m0_wdata = mwdata[0][0];
    assign ifa.m0_wstrb = mwstrb[0][0];
    assign ifa.m1_valid = mvalid[0][1];
    assign ifa.m1_addr  = maddr[0][1];
    assign ifa.m1_wdata = mwdata[0][1];
    assign ifa.m1_wstrb = mwstrb[0][1];
    assign ifa.s_ready  = sready[0];
    assign ifa.s_rdata  = srdata[0];
    assign mready[0]    = {ifa.m1_ready, ifa.m0_ready};
    assign mrdata[0][0] = ifa.m0_rdata;
    assign mrdata[0][1] = ifa.m1_rdata;
    assign svalid[0]    = ifa.s_valid;
    assign saddr[0]     = ifa.s_addr;
    assign swdata[0]    = ifa.s_wdata;
    assign swstrb[0]    = ifa.s_wstrb;
    assign grant[0]     = ifa.grant;
    assign initd[0]     = ifa.init_done;
    assign terr[0]      = ifa.timeout_err;

    assign ifb.m0_valid = mvalid[1][0];
    assign ifb.m0_addr  = maddr[1][0];
    assign ifb.m0_wdata = mwdata[1][0];
    assign ifb.m0_wstrb = mwstrb[1][0];
    assign ifb.m1_valid = mvalid[1][1];
    assign ifb.m1_addr  = maddr[1][1];
    assign ifb.m1_wdata = mwdata[1][1];
    assign ifb.m1_wstrb = mwstrb[1][1];
    assign ifb.s_ready  = sready[1];
    assign ifb.s_rdata  = srdata[1];
    assign mready[1]    = {ifb.m1_ready, ifb.m0_ready};
    assign mrdata[1][0] = ifb.m0_rdata;
    assign mrdata[1][1] = ifb.m1_rdata;
    assign svalid[1]    = ifb.s_valid;
    assign saddr[1]     = ifb.s_addr;
    assign swdata[1]    = ifb.s_wdata;
    assign swstrb[1]    = ifb.s_wstrb;
    assign grant[1]     = ifb.grant;
    assign initd[1]     = ifb.init_done;
    assign terr[1]      = ifb.timeout_err;

    int nvec;
    int nerr;

    task automatic chk(input int k, input string n,
                       input logic [31:0] a, input logic [31:0] e);
        nvec++;
        if (a !== e) begin
            nerr++;
            $display("FAIL %s[%0d] @%0t: got %h expected %h", n, k, $time, a, e);
        end
    endtask

    function automatic logic [31:0] memf(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0000;
    endfunction

    // Model: phase 0 waiting for init, 1 idle, 2 request out, 3 ready release
    int          ph    [2];
    int          ecnt  [2];
    logic [1:0]  egrant[2];
    logic [1:0]  erdy  [2];
    logic [31:0] erd   [2][2];
    logic        einit [2];
    logic        eterr [2];
    int          elast [2];

    function automatic int tmo(input int k);
        return (k == 0) ? 8 : 0;
    endfunction

    task automatic mreset(input int k);
        ph[k]     = 0;
        ecnt[k]   = 0;
        egrant[k] = 2'b00;
        erdy[k]   = 2'b00;
        erd[k][0] = 32'd0;
        erd[k][1] = 32'd0;
        einit[k]  = 1'b0;
        eterr[k]  = 1'b0;
        elast[k]  = 1;
    endtask

    task automatic mstep(input int k);
        int          w;
        bit          fin;
        logic [31:0] d;
        erdy[k] = 2'b00;
        fin = 1'b0;
        d = 32'd0;
        w = egrant[k][1] ? 1 : 0;
        case (ph[k])
            0: if (sready[k]) begin
                ph[k] = 1;
                einit[k] = 1'b1;
            end
            1: if (mvalid[k] != 2'b00) begin
                if (mvalid[k] == 2'b11)
                    w = (k == 1) ? 0 : 1 - elast[k];
                else
                    w = mvalid[k][1] ? 1 : 0;
                egrant[k] = (w == 1) ? 2'b10 : 2'b01;
                ecnt[k] = 0;
                ph[k] = 2;
            end
            2: begin
                ecnt[k]++;
                if (sready[k]) begin
                    fin = 1'b1;
                    d = srdata[k];
                end else if (tmo(k) != 0 && ecnt[k] == tmo(k)) begin
                    fin = 1'b1;
                    eterr[k] = 1'b1;
                end
                if (fin) begin
                    erdy[k][w] = 1'b1;
                    erd[k][w] = d;
                    elast[k] = w;
                    ph[k] = 3;
                end
            end
            3: if (!sready[k]) begin
                egrant[k] = 2'b00;
                ph[k] = 1;
            end
            default: ;
        endcase
    endtask

    task automatic check_all();
        for (int k = 0; k < 2; k++) begin
            int w;
            bit act;
            w = egrant[k][1] ? 1 : 0;
            act = (ph[k] >= 2);
            chk(k, "s_valid", {31'd0, svalid[k]}, {31'd0, ph[k] == 2});
            chk(k, "s_addr", saddr[k], act ? maddr[k][w] : 32'd0);
            chk(k, "s_wdata", swdata[k], act ? mwdata[k][w] : 32'd0);
            chk(k, "s_wstrb", {28'd0, swstrb[k]},
                {28'd0, act ? mwstrb[k][w] : 4'd0});
            chk(k, "grant", {30'd0, grant[k]}, {30'd0, egrant[k]});
            chk(k, "m_ready", {30'd0, mready[k]}, {30'd0, erdy[k]});
            chk(k, "m0_rdata", mrdata[k][0], erd[k][0]);
            chk(k, "m1_rdata", mrdata[k][1], erd[k][1]);
            chk(k, "init_done", {31'd0, initd[k]}, {31'd0, einit[k]});
            chk(k, "timeout_err", {31'd0, terr[k]}, {31'd0, eterr[k]});
        end
    endtask

    initial forever begin
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) mreset(k);
            else mstep(k);
        end
    end

    initial forever begin
        @(negedge rst_n);
        for (int k = 0; k < 2; k++) mreset(k);
    end

    initial forever begin
        @(posedge clk);
        #1;
        check_all();
    end

    // Masters and memory stimulus
    bit men   [2][2];
    bit reiss [2][2];
    int rcnt  [2][2];
    bit hang  [2];
    bit ipulse[2];
    int lat   [2];
    int wcnt  [2];
    int hold  [2];
    bit rd_only;
    bit chk_rd;
    bit rnd;
    int done_q[$];

    task automatic new_req(input int k, input int j);
        maddr[k][j]  = $urandom & 32'hFFFF_FFFC;
        mwdata[k][j] = $urandom;
        mwstrb[k][j] = rd_only ? 4'd0 : 4'($urandom_range(0, 15));
        mvalid[k][j] = 1'b1;
    endtask

    task automatic master_step(input int k, input int j);
        if (mready[k][j]) begin
            rcnt[k][j]++;
            if (k == 0) done_q.push_back(j);
            if (chk_rd && k == 0)
                chk(k, "rdata_mem", mrdata[k][j], memf(maddr[k][j]));
            if (men[k][j] && (reiss[k][j] || $urandom_range(0, 1) == 1))
                new_req(k, j);
            else
                mvalid[k][j] = 1'b0;
        end else if (!mvalid[k][j] && men[k][j] && $urandom_range(0, 3) == 0) begin
            new_req(k, j);
        end
    endtask

    task automatic sd_step(input int k);
        if (!rst_n) begin
            sready[k] = 1'b0;
            wcnt[k] = 0;
            hold[k] = 0;
        end else if (ipulse[k]) begin
            sready[k] = 1'b1;
            srdata[k] = $urandom;
            ipulse[k] = 1'b0;
            hold[k] = 0;
        end else if (svalid[k]) begin
            if (hang[k]) begin
                sready[k] = 1'b0;
            end else if (wcnt[k] >= lat[k]) begin
                sready[k] = 1'b1;
                srdata[k] = memf(saddr[k]);
            end else begin
                wcnt[k]++;
                sready[k] = 1'b0;
                srdata[k] = $urandom;
            end
        end else begin
            wcnt[k] = 0;
            if (sready[k] && hold[k] > 0) begin
                hold[k]--;
            end else begin
                sready[k] = 1'b0;
                srdata[k] = $urandom;
                hold[k] = rnd ? $urandom_range(0, 2) : 0;
                if (rnd) lat[k] = $urandom_range(0, 4);
            end
        end
    endtask

    initial forever begin
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            sd_step(k);
            if (rst_n) begin
                master_step(k, 0);
                master_step(k, 1);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
        #2;
    endtask

    task automatic drain(input int k);
        int i;
        i = 0;
        while ((mvalid[k] != 2'b00 || grant[k] != 2'b00) && i < 100) begin
            tick(1);
            i++;
        end
        chk(k, "drain", {30'd0, grant[k]}, 32'd0);
    endtask

    task automatic wait_sv(input int k);
        int i;
        i = 0;
        while (!svalid[k] && i < 60) begin
            tick(1);
            i++;
        end
        chk(k, "wait_svalid", {31'd0, svalid[k]}, 32'd1);
    endtask

    initial begin
        int i;
        int n;
        int r0;
        int r1;
        nvec = 0;
        nerr = 0;
        rst_n = 1'b0;
        rd_only = 1'b1;
        chk_rd = 1'b0;
        rnd = 1'b0;
        for (int k = 0; k < 2; k++) begin
            mvalid[k] = 2'b00;
            sready[k] = 1'b0;
            srdata[k] = 32'd0;
            hang[k] = 1'b0;
            ipulse[k] = 1'b0;
            lat[k] = 3;
            wcnt[k] = 0;
            hold[k] = 0;
            mreset(k);
            for (int j = 0; j < 2; j++) begin
                maddr[k][j] = 32'd0;
                mwdata[k][j] = 32'd0;
                mwstrb[k][j] = 4'd0;
                men[k][j] = 1'b0;
                reiss[k][j] = 1'b1;
                rcnt[k][j] = 0;
            end
        end
        tick(3);
        chk(0, "rst_grant", {30'd0, grant[0]}, 32'd0);
        rst_n = 1'b1;

        // Init wait with both masters already requesting, then round-robin
        for (int k = 0; k < 2; k++) begin
            men[k][0] = 1'b1;
            men[k][1] = 1'b1;
            new_req(k, 0);
            new_req(k, 1);
        end
        chk_rd = 1'b1;
        tick(20);
        chk(0, "init_svalid", {31'd0, svalid[0]}, 32'd0);
        chk(0, "init_pre", {31'd0, initd[0]}, 32'd0);
        ipulse[0] = 1'b1;
        ipulse[1] = 1'b1;
        tick(2);
        chk(0, "init_post", {31'd0, initd[0]}, 32'd1);
        i = 0;
        while (done_q.size() < 4 && i < 300) begin
            tick(1);
            i++;
        end
        men[0][0] = 1'b0;
        men[0][1] = 1'b0;
        chk(0, "rr_done", {31'd0, done_q.size() >= 4}, 32'd1);
        for (int q = 0; q < 4; q++)
            if (q < done_q.size()) chk(0, "rr_order", done_q[q], q % 2);
        drain(0);
        chk(1, "fixed_starve", rcnt[1][1], 32'd0);
        chk(1, "fixed_m0", {31'd0, rcnt[1][0] > 2}, 32'd1);
        men[1][0] = 1'b0;

        // Single write from m0
        r0 = rcnt[0][0];
        r1 = rcnt[0][1];
        maddr[0][0] = 32'h10;
        mwdata[0][0] = 32'hFFFE_0001;
        mwstrb[0][0] = 4'hF;
        mvalid[0][0] = 1'b1;
        wait_sv(0);
        chk(0, "wr_addr", saddr[0], 32'h10);
        chk(0, "wr_wdata", swdata[0], 32'hFFFE_0001);
        chk(0, "wr_wstrb", {28'd0, swstrb[0]}, 32'hF);
        chk(0, "wr_grant", {30'd0, grant[0]}, 32'd1);
        drain(0);
        chk(0, "wr_m0_pulses", rcnt[0][0] - r0, 32'd1);
        chk(0, "wr_m1_pulses", rcnt[0][1] - r1, 32'd0);
        chk_rd = 1'b0;

        // Watchdog: memory never answers
        hang[0] = 1'b1;
        new_req(0, 0);
        n = 0;
        i = 0;
        while (!mready[0][0] && i < 40) begin
            if (svalid[0]) n++;
            tick(1);
            i++;
        end
        chk(0, "wd_req_cycles", n, 32'd8);
        chk(0, "wd_rdata", mrdata[0][0], 32'd0);
        chk(0, "wd_err", {31'd0, terr[0]}, 32'd1);
        drain(0);
        hang[0] = 1'b0;
        rd_only = 1'b0;
        new_req(0, 1);
        wait_sv(0);
        drain(0);
        chk(0, "wd_sticky", {31'd0, terr[0]}, 32'd1);
        chk(1, "fixed_m1_served", {31'd0, rcnt[1][1] > 0}, 32'd1);

        // Random traffic on both instances
        rnd = 1'b1;
        for (int k = 0; k < 2; k++)
            for (int j = 0; j < 2; j++) begin
                men[k][j] = 1'b1;
                reiss[k][j] = 1'b0;
            end
        tick(600);

        // Asynchronous reset in the middle of a request
        wait_sv(0);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk(0, "arst_svalid", {31'd0, svalid[0]}, 32'd0);
        chk(0, "arst_grant", {30'd0, grant[0]}, 32'd0);
        chk(0, "arst_ready", {30'd0, mready[0]}, 32'd0);
        chk(0, "arst_rdata0", mrdata[0][0], 32'd0);
        chk(0, "arst_saddr", saddr[0], 32'd0);
        chk(0, "arst_terr", {31'd0, terr[0]}, 32'd0);
        check_all();
        for (int k = 0; k < 2; k++) begin
            mvalid[k] = 2'b00;
            men[k][0] = 1'b0;
            men[k][1] = 1'b0;
        end
        tick(2);
        rst_n = 1'b1;
        tick(3);
        chk(0, "post_rst_init", {31'd0, initd[0]}, 32'd0);
        chk(0, "post_rst_svalid", {31'd0, svalid[0]}, 32'd0);
        for (int k = 0; k < 2; k++) begin
            ipulse[k] = 1'b1;
            men[k][0] = 1'b1;
            men[k][1] = 1'b1;
        end
        tick(200);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/sdram_arbiter.md
Name: sdram_arbiter

Overview:
- Two-requester arbiter that shares the single sys_sdram valid/ready port between two masters.
- Typical masters are the read/write checker and a CPU native memory bus.
- Owns the sys_sdram handshake sequencing:
  - wait for controller init;
  - assert valid and hold it until ready;
  - wait for ready to drop.
- Returns a one-cycle ready pulse plus the read data to the granted master.

Parameters:
- P_FIXED, 0, 1 = fixed priority (m0 always wins); 0 = round-robin.
- P_TIMEOUT, 16'd0, max cycles in S_REQ waiting for s_ready. 0 disables the watchdog.

Ports:
- clk  in  1  system clock; single clock domain.
- rst_n  in  1  asynchronous active-low reset.
- m0_valid  in  1  master 0 request; held high until m0_ready pulse.
- m0_ready  out  1  one-cycle completion pulse to master 0.
- m0_addr  in  32  master 0 byte address.
- m0_wdata  in  32  master 0 write data.
- m0_wstrb  in  4  master 0 byte strobes; 0000 = read.
- m0_rdata  out  32  master 0 read data, valid with m0_ready.
- m1_valid, m1_ready, m1_addr, m1_wdata, m1_wstrb, m1_rdata: same as m0_* for master 1.
- s_valid  out  1  request to sys_sdram.
- s_ready  in  1  sys_sdram ready/level.
- s_addr  out  32  address to sys_sdram.
- s_wdata  out  32  write data to sys_sdram.
- s_wstrb  out  4  strobes to sys_sdram.
- s_rdata  in  32  read data from sys_sdram.
- grant  out  2  one-hot grant owner; 00 when idle.
- init_done  out  1  high once sys_sdram has first signalled ready.
- timeout_err  out  1  sticky watchdog flag.

Behaviour:
- Reset values (asynchronous on rst_n low):
  - state = S_INIT;
  - all outputs 0, including grant = 00, m*_rdata = 0, m*_ready = 0, timeout_err = 0;
  - round-robin pointer = "last = m1", so m0 wins the first tie.
- Reset mid-transaction aborts immediately with no ready pulse. Masters must also be reset.
- States:
  - S_INIT: s_valid = 0.
    - s_ready = 1 → S_IDLE, and init_done is set (registered, stays 1).
    - m*_valid is ignored in this state.
  - S_IDLE:
    - No m*_valid → stay.
    - Only one master valid → grant it.
    - Both valid:
      - P_FIXED = 1 → m0;
      - otherwise the master not granted last.
    - Grant is registered; next state is S_REQ.
    - Request sampled in cycle t → s_valid = 1 in cycle t+1.
  - S_REQ: s_valid = 1; s_addr, s_wdata and s_wstrb are muxed combinationally from the granted master.
    - s_ready = 1 → S_WAIT. In the next cycle:
      - the granted m*_ready = 1 for exactly one cycle;
      - the granted m*_rdata is loaded with s_rdata (sampled in the s_ready cycle);
      - the round-robin pointer is updated.
    - Watchdog (P_TIMEOUT ≠ 0): a 16-bit counter clears on entry to S_REQ and increments each S_REQ cycle.
      - When it reaches P_TIMEOUT with s_ready still 0: set timeout_err, pulse m*_ready with m*_rdata = 0, go to S_WAIT.
  - S_WAIT: s_valid = 0; s_addr, s_wdata and s_wstrb stay driven from the grant.
    - s_ready = 0 → S_IDLE; grant returns to 00.
    - Minimum back-to-back spacing: IDLE → REQ → WAIT → IDLE, which is 3 cycles plus the sys_sdram latency.
- Outside S_REQ/S_WAIT: s_addr, s_wdata and s_wstrb are 0.
- Ready pulse on the same cycle as the entry to S_WAIT: s_ready = 0 then means the transition to S_IDLE happens immediately on the following cycle.
- The non-granted master's valid is held pending and never loses its request. Its ready and rdata are unchanged.
- Granted master dropping valid early is a protocol violation. The arbiter completes the access regardless.
- The non-granted master's m*_rdata retains its previous value.
- timeout_err is cleared only by rst_n.

Test Plan:
1. Init: s_ready held 0 for 20 cycles with m0_valid = 1; then s_ready = 1 for 1 cycle.
   - Required: s_valid stays 0 throughout;
   - init_done rises the cycle after s_ready;
   - m0 is granted afterwards.
2. Single write: m0 requests addr 0x10, wdata 0xFFFE0001, wstrb 1111; sdram model asserts s_ready 3 cycles after s_valid.
   - Required: s_* match m0 exactly;
   - m0_ready pulses once;
   - grant = 01 → 00 after s_ready falls.
3. Round-robin: m0 and m1 both hold valid for 4 reads, P_FIXED = 0.
   - Required: grants are m0, m1, m0, m1;
   - each m*_rdata equals the model data for its address;
   - no ready pulse goes to the wrong master.
4. Fixed priority: P_FIXED = 1, m0 re-requests immediately after each ready, m1 valid continuously.
   - Required: m1 is never granted while m0_valid is high in S_IDLE;
   - m1 is granted in the first S_IDLE where m0_valid = 0.
5. Watchdog: P_TIMEOUT = 8, model never asserts s_ready.
   - Required: m0_ready pulses after 8 S_REQ cycles with m0_rdata = 0;
   - timeout_err = 1 and stays 1 through later good transactions.
6. Reset mid-op: drop rst_n during S_REQ.
   - Required: all outputs 0 immediately (asynchronous);
   - after release, state is S_INIT and init_done = 0.
